// File: rtl/pc_sequencer.sv
// Program counter owner and instruction-fetch sequencer: next-PC selection, imem req/ack
// handshake with timeout, and a held instruction slot for decode. Optional: MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jalr,
  input  logic [31:0] i_alu_out,
  input  logic        i_trap,
  input  logic [31:0] i_trap_vector,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst_out,
  output logic [31:0] o_inst_pc,
  output logic        o_fetch_err,
  output logic        o_misalign_exc
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_GAP, S_VALID} state_t;

  localparam logic [15:0] TO_LAST = (ACK_TIMEOUT > 0) ? 16'(ACK_TIMEOUT - 1) : 16'd0;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [15:0] r_cnt;
  logic [31:0] r_inst_out;
  logic [31:0] r_inst_pc;
  logic        r_fetch_err;
  logic [31:0] w_next_pc;
  logic [31:0] w_redir;
  logic        w_take;
  logic        w_accept;
  logic        w_to_fire;
  logic        w_timeout;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] jalr_target(input logic [31:0] a);
    return {a[31:1], 1'b0};
  endfunction

  assign w_redir   = i_jalr ? jalr_target(i_alu_out) : i_branch_target;
  assign w_timeout = (ACK_TIMEOUT != 0) && (r_cnt == TO_LAST);

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misalign;

  // A redirect into a halfword-aligned target diverts to the trap vector instead.
  always_comb begin
    w_misalign = 1'b0;
    w_next_pc  = r_pc + 32'd4;
    if (i_trap) begin
      w_next_pc = i_trap_vector;
    end else if (i_jalr || i_branch_taken) begin
      if (w_redir[1]) begin
        w_next_pc  = i_trap_vector;
        w_misalign = 1'b1;
      end else begin
        w_next_pc = align_word(w_redir);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_accept & w_misalign;
  end

  assign o_misalign_exc = r_misalign;
`else
  always_comb begin
    w_next_pc = r_pc + 32'd4;
    if (i_trap)                          w_next_pc = i_trap_vector;
    else if (i_jalr || i_branch_taken)   w_next_pc = align_word(w_redir);
  end

  assign o_misalign_exc = 1'b0;
`endif

  // Ack takes precedence over a timeout landing in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_accept    = 1'b0;
    w_to_fire   = 1'b0;
    case (r_state)
      S_BOOT:  w_state_nxt = S_REQ;
      S_REQ: begin
        if (i_imem_ack) begin
          w_state_nxt = S_VALID;
          w_take      = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = S_GAP;
          w_to_fire   = 1'b1;
        end
      end
      S_GAP:   w_state_nxt = S_REQ;
      S_VALID: begin
        if (!i_stall) begin
          w_state_nxt = S_REQ;
          w_accept    = 1'b1;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_cnt       <= 16'd0;
      r_inst_out  <= 32'd0;
      r_inst_pc   <= 32'd0;
      r_fetch_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_err <= w_to_fire;
      if (r_state == S_REQ && !i_imem_ack && !w_to_fire) r_cnt <= r_cnt + 16'd1;
      else                                               r_cnt <= 16'd0;
      if (w_take) begin
        r_inst_out <= i_imem_rdata;
        r_inst_pc  <= r_pc;
      end
      if (w_accept) r_pc <= w_next_pc;
    end
  end

  assign o_imem_req   = (r_state == S_REQ);
  assign o_imem_addr  = r_pc;
  assign o_inst_valid = (r_state == S_VALID);
  assign o_inst_out   = r_inst_out;
  assign o_inst_pc    = r_inst_pc;
  assign o_fetch_err  = r_fetch_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations; honours MISALIGN_TRAP_EN.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_stall, i_branch_taken, i_jalr, i_trap, i_imem_ack;
  logic [31:0] i_branch_target, i_alu_out, i_trap_vector, i_imem_rdata;
  logic        o_imem_req, o_inst_valid, o_fetch_err, o_misalign_exc;
  logic [31:0] o_imem_addr, o_inst_out, o_inst_pc;

  int n_chk = 0;
  int n_err = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .i_stall(i_stall),
    .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
    .i_jalr(i_jalr), .i_alu_out(i_alu_out),
    .i_trap(i_trap), .i_trap_vector(i_trap_vector),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
    .o_inst_valid(o_inst_valid), .o_inst_out(o_inst_out), .o_inst_pc(o_inst_pc),
    .o_fetch_err(o_fetch_err), .o_misalign_exc(o_misalign_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_redirect;
    i_trap = 1'b0; i_jalr = 1'b0; i_branch_taken = 1'b0;
  endtask

  // Expects a pending request at addr; acks one cycle later and checks the held slot.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] word);
    int w;
    w = 0;
    while (!o_imem_req && w < 20) begin
      tick;
      w++;
    end
    chk("req_wait", w, 0);
    chk("req_addr", o_imem_addr, addr);
    tick;
    chk("req_hold", {31'd0, o_imem_req}, 1);
    i_imem_ack = 1'b1; i_imem_rdata = word;
    tick;
    i_imem_ack = 1'b0; i_imem_rdata = 32'd0;
    chk("valid", {31'd0, o_inst_valid}, 1);
    chk("inst_out", o_inst_out, word);
    chk("inst_pc", o_inst_pc, addr);
    chk("req_off", {31'd0, o_imem_req}, 0);
  endtask

  task automatic accept;
    tick;
    clear_redirect();
  endtask

  initial begin
    rst = 1'b1; i_stall = 1'b0; i_imem_ack = 1'b0; i_imem_rdata = 32'd0;
    i_branch_target = 32'd0; i_alu_out = 32'd0; i_trap_vector = 32'd0;
    clear_redirect();
    tick; tick;
    chk("rst_req", {31'd0, o_imem_req}, 0);
    chk("rst_valid", {31'd0, o_inst_valid}, 0);
    chk("rst_inst_out", o_inst_out, 0);
    chk("rst_inst_pc", o_inst_pc, 0);
    chk("rst_ferr", {31'd0, o_fetch_err}, 0);
    chk("rst_mis", {31'd0, o_misalign_exc}, 0);
    rst = 1'b0;
    tick;

    // sequential fetch, 3-cycle cadence
    for (int k = 0; k < 5; k++) begin
      fetch(32'(k * 4), 32'h1000_0000 + 32'(k));
      if (k < 4) accept();
    end

    // stall at 0x10 with redirect and a stray ack that must both be ignored
    i_stall = 1'b1; i_trap = 1'b1; i_trap_vector = 32'h80;
    i_imem_ack = 1'b1; i_imem_rdata = 32'hDEAD_BEEF;
    for (int s = 0; s < 4; s++) begin
      tick;
      i_imem_ack = 1'b0;
      chk("stall_valid", {31'd0, o_inst_valid}, 1);
      chk("stall_pc", o_inst_pc, 32'h10);
      chk("stall_inst", o_inst_out, 32'h1000_0004);
      chk("stall_req", {31'd0, o_imem_req}, 0);
    end
    i_trap = 1'b0; i_stall = 1'b0;
    tick;
    chk("release_req", {31'd0, o_imem_req}, 1);
    chk("release_addr", o_imem_addr, 32'h14);

    // jalr beats branch, bit0 cleared
    fetch(32'h14, 32'h2000_0014);
    i_jalr = 1'b1; i_alu_out = 32'h101; i_branch_taken = 1'b1; i_branch_target = 32'h200;
    accept();
    chk("jalr_addr", o_imem_addr, 32'h100);

    // trap beats jalr
    fetch(32'h100, 32'h2000_0100);
    i_trap = 1'b1; i_trap_vector = 32'h80; i_jalr = 1'b1; i_alu_out = 32'h300;
    accept();
    chk("trap_addr", o_imem_addr, 32'h80);
    chk("trap_mis", {31'd0, o_misalign_exc}, 0);

    // misaligned branch target
    fetch(32'h80, 32'h2000_0080);
    i_branch_taken = 1'b1; i_branch_target = 32'h102; i_trap_vector = 32'h40;
    accept();
`ifdef MISALIGN_TRAP_EN
    chk("mis_addr", o_imem_addr, 32'h40);
    chk("mis_pulse", {31'd0, o_misalign_exc}, 1);
`else
    chk("mis_addr", o_imem_addr, 32'h100);
    chk("mis_pulse", {31'd0, o_misalign_exc}, 0);
`endif

    // timeout: 4 REQ cycles, 1-cycle gap with fetch_err, same address reissued
    begin
      logic [31:0] a;
`ifdef MISALIGN_TRAP_EN
      a = 32'h40;
`else
      a = 32'h100;
`endif
      for (int c = 0; c < 3; c++) begin
        tick;
        chk("to_req", {31'd0, o_imem_req}, 1);
        chk("to_ferr_lo", {31'd0, o_fetch_err}, 0);
        chk("to_mis_lo", {31'd0, o_misalign_exc}, 0);
      end
      tick;
      chk("to_gap", {31'd0, o_imem_req}, 0);
      chk("to_ferr", {31'd0, o_fetch_err}, 1);
      tick;
      chk("to_reissue", {31'd0, o_imem_req}, 1);
      chk("to_addr", o_imem_addr, a);
      chk("to_ferr_end", {31'd0, o_fetch_err}, 0);
      // ack on the timeout cycle wins
      tick; tick; tick;
      chk("late_req", {31'd0, o_imem_req}, 1);
      i_imem_ack = 1'b1; i_imem_rdata = 32'h3000_0000;
      tick;
      i_imem_ack = 1'b0;
      chk("late_valid", {31'd0, o_inst_valid}, 1);
      chk("late_ferr", {31'd0, o_fetch_err}, 0);
      chk("late_pc", o_inst_pc, a);
      chk("late_inst", o_inst_out, 32'h3000_0000);
    end

    // pc+4 wraps to 0
    i_trap = 1'b1; i_trap_vector = 32'hFFFF_FFFC;
    accept();
    fetch(32'hFFFF_FFFC, 32'h4000_0000);
    accept();
    chk("wrap_addr", o_imem_addr, 32'h0);
    fetch(32'h0, 32'h4000_0001);
    accept();
    chk("pre_rst_addr", o_imem_addr, 32'h4);

    // reset mid-handshake with a coincident ack
    tick;
    rst = 1'b1; i_imem_ack = 1'b1; i_imem_rdata = 32'hBAD0_BAD0;
    tick;
    rst = 1'b0; i_imem_ack = 1'b0;
    chk("mrst_req", {31'd0, o_imem_req}, 0);
    chk("mrst_valid", {31'd0, o_inst_valid}, 0);
    chk("mrst_inst", o_inst_out, 0);
    chk("mrst_pc", o_inst_pc, 0);
    chk("mrst_addr", o_imem_addr, 0);
    tick;
    fetch(32'h0, 32'h5000_0000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
